axil_fnd_scan_ctrl: RTL and testbench



---
 rtl/axil_fnd_scan_ctrl.sv | 279 +++++++++++++++++++++++++++
 tb/tb_axil_fnd_scan_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/axil_fnd_scan_ctrl.sv
// AXI4-Lite multiplexed seven-segment display controller: hex/decimal modes, scan prescaler, blink, status.
// Optional macro FND_LEADING_ZERO_BLANK_EN blanks leading zero digits in decimal mode.
module axil_fnd_scan_ctrl #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 4,
  parameter int          NUM_DIGITS         = 4,
  parameter bit          COM_ACTIVE_LOW     = 1'b1,
  parameter bit          SEG_ACTIVE_LOW     = 1'b1,
  parameter logic [15:0] DEFAULT_PRESCALE   = 16'd49999
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [NUM_DIGITS-1:0]           fnd_com,
  output logic [7:0]                      fnd_seg
);

  localparam int          VW         = 4 * NUM_DIGITS;
  localparam int          BCD_DIGITS = NUM_DIGITS + 2;
  localparam int          BW         = 4 * BCD_DIGITS;
  localparam logic [63:0] VMASK64    = (64'd1 << VW) - 64'd1;
  localparam logic [31:0] VALUE_MASK = VMASK64[31:0];
  localparam logic [31:0] CTRL_MASK  = 32'h00FF_0007;
  localparam logic [2:0]  LAST_IDX   = 3'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} conv_state_e;

  logic        awready_q, bvalid_q, arready_q, rvalid_q;
  logic [31:0] rdata_q, ctrl_q, value_q, prescale_q;
  logic        value_wr_q, ctrl_wr_q;
  logic        wr_hs, rd_hs;
  logic [1:0]  wr_sel, rd_sel;
  logic [31:0] wr_old, wr_merged, rd_word, status_word;

  conv_state_e     state_q;
  logic [VW-1:0]   bin_q, disp_q;
  logic [BW-1:0]   bcd_q, bcd_adj, bcd_shift;
  logic [5:0]      cnt_q;
  logic            overflow_q, busy;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;

  logic [15:0] presc_q, frame_q;
  logic [2:0]  idx_q;
  logic        blink_on_q, presc_wrap, frame_end, frame_wrap;

  logic [3:0]            cur_nib;
  logic                  cur_blank;
  logic [NUM_DIGITS-1:0] com_onehot, com_d;
  logic [7:0]            seg_raw, dp_mask;
  logic [NUM_DIGITS-1:0] fnd_com_q;
  logic [7:0]            fnd_seg_q;
  logic                  unused_ok;

  function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] din,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = din[8*b +: 8];
    return r;
  endfunction

  // Segment order is {g,f,e,d,c,b,a}, active-high before polarity is applied.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;  4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;  4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;  4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;  4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  assign wr_hs  = awready_q & s00_axi_awvalid & s00_axi_wvalid;
  assign rd_hs  = arready_q & s00_axi_arvalid;
  assign wr_sel = s00_axi_awaddr[3:2];
  assign rd_sel = s00_axi_araddr[3:2];
  assign busy   = (state_q != ST_IDLE);
  assign status_word = {21'd0, idx_q, 6'd0, overflow_q, busy};

  always_comb begin
    case (wr_sel)
      2'd0:    wr_old = ctrl_q;
      2'd1:    wr_old = value_q;
      2'd2:    wr_old = prescale_q;
      default: wr_old = 32'd0;
    endcase
    wr_merged = apply_strb(wr_old, s00_axi_wdata, s00_axi_wstrb);
    case (rd_sel)
      2'd0:    rd_word = ctrl_q;
      2'd1:    rd_word = value_q;
      2'd2:    rd_word = prescale_q;
      default: rd_word = status_word;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      awready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'd0;
      ctrl_q     <= 32'd0;
      value_q    <= 32'd0;
      prescale_q <= {16'd0, DEFAULT_PRESCALE};
      value_wr_q <= 1'b0;
      ctrl_wr_q  <= 1'b0;
    end else begin
      awready_q  <= !awready_q && s00_axi_awvalid && s00_axi_wvalid && !bvalid_q;
      arready_q  <= !arready_q && s00_axi_arvalid && !rvalid_q;
      value_wr_q <= wr_hs && (wr_sel == 2'd1);
      ctrl_wr_q  <= wr_hs && (wr_sel == 2'd0);
      if (wr_hs) begin
        bvalid_q <= 1'b1;
        case (wr_sel)
          2'd0:    ctrl_q     <= wr_merged & CTRL_MASK;
          2'd1:    value_q    <= wr_merged & VALUE_MASK;
          2'd2:    prescale_q <= wr_merged;
          default: ;
        endcase
      end else if (bvalid_q && s00_axi_bready) begin
        bvalid_q <= 1'b0;
      end
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_word;
      end else if (rvalid_q && s00_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Double-dabble add-3 step on every BCD digit, then shift in the next binary bit.
  for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
    assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                             : bcd_q[4*gi +: 4];
  end
  assign bcd_shift = {bcd_adj[BW-2:0], bin_q[VW-1]};

`ifdef FND_LEADING_ZERO_BLANK_EN
  logic lz_run;
  always_comb begin
    lz_run  = 1'b1;
    blank_d = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (bcd_q[4*k +: 4] != 4'd0) lz_run = 1'b0;
      blank_d[k] = lz_run;
    end
  end
`else
  assign blank_d = '0;
`endif

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q    <= ST_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= 6'd0;
      disp_q     <= '0;
      overflow_q <= 1'b0;
      blank_q    <= '0;
    end else if (value_wr_q || ctrl_wr_q) begin
      if (ctrl_q[1]) begin
        state_q <= ST_SHIFT;
        bin_q   <= value_q[VW-1:0];
        bcd_q   <= '0;
        cnt_q   <= 6'd0;
      end else begin
        state_q <= ST_IDLE;
        disp_q  <= value_q[VW-1:0];
        blank_q <= '0;
      end
    end else begin
      case (state_q)
        ST_SHIFT: begin
          bin_q <= bin_q << 1;
          bcd_q <= bcd_shift;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'(VW - 1)) state_q <= ST_DONE;
        end
        ST_DONE: begin
          disp_q     <= bcd_q[VW-1:0];
          overflow_q <= |bcd_q[BW-1:VW];
          blank_q    <= blank_d;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign presc_wrap = (presc_q >= prescale_q[15:0]);
  assign frame_end  = presc_wrap && (idx_q == LAST_IDX);
  assign frame_wrap = frame_end && (frame_q >= prescale_q[31:16]);

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      presc_q    <= 16'd0;
      idx_q      <= 3'd0;
      frame_q    <= 16'd0;
      blink_on_q <= 1'b1;
    end else begin
      if (!ctrl_q[0]) begin
        presc_q <= 16'd0;
        idx_q   <= 3'd0;
        frame_q <= 16'd0;
      end else begin
        if (wr_hs && (wr_sel == 2'd2)) presc_q <= 16'd0;
        else if (presc_wrap)           presc_q <= 16'd0;
        else                           presc_q <= presc_q + 16'd1;
        if (presc_wrap) idx_q <= (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
        if (frame_end)  frame_q <= frame_wrap ? 16'd0 : frame_q + 16'd1;
      end
      if (!ctrl_q[2])                  blink_on_q <= 1'b1;
      else if (ctrl_q[0] && frame_wrap) blink_on_q <= ~blink_on_q;
    end
  end

  assign dp_mask = ctrl_q[23:16];

  always_comb begin
    cur_nib    = 4'd0;
    cur_blank  = 1'b0;
    com_onehot = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == 3'(k)) begin
        cur_nib       = disp_q[4*k +: 4];
        cur_blank     = blank_q[k];
        com_onehot[k] = 1'b1;
      end
    end
    com_d   = (ctrl_q[0] && (!ctrl_q[2] || blink_on_q)) ? com_onehot : '0;
    seg_raw = ctrl_q[0] ? {dp_mask[idx_q], cur_blank ? 7'd0 : glyph(cur_nib)} : 8'd0;
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      fnd_com_q <= {NUM_DIGITS{COM_ACTIVE_LOW}};
      fnd_seg_q <= {8{SEG_ACTIVE_LOW}};
    end else begin
      fnd_com_q <= COM_ACTIVE_LOW ? ~com_d : com_d;
      fnd_seg_q <= SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    end
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = awready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = 2'b00;
  assign fnd_com         = fnd_com_q;
  assign fnd_seg         = fnd_seg_q;

  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                       s00_axi_araddr[1:0], bcd_adj[BW-1]};

endmodule

// File: tb/tb_axil_fnd_scan_ctrl.sv
// Directed self-checking bench for axil_fnd_scan_ctrl (4 digits, active-low com and seg).
module tb_axil_fnd_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [3:0]  fnd_com;
  logic [7:0]  fnd_seg;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axil_fnd_scan_ctrl #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .NUM_DIGITS(4),
    .COM_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1), .DEFAULT_PRESCALE(16'd49999)
  ) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .fnd_com(fnd_com), .fnd_seg(fnd_seg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: timed out waiting for DUT", tag);
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (awready !== 1'b1) timeout_fail("awready");
    chk("wready", {31'd0, wready}, 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (bvalid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (bvalid !== 1'b1) timeout_fail("bvalid");
    chk("bresp", {30'd0, bresp}, 32'd0);
    @(posedge clk); #1;
    bready = 1'b0;
    $display("write addr=%h data=%h strb=%b", a, d, s);
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (arready !== 1'b1) timeout_fail("arready");
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (rvalid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (rvalid !== 1'b1) timeout_fail("rvalid");
    d = rdata;
    chk("rresp", {30'd0, rresp}, 32'd0);
    @(posedge clk); #1;
    rready = 1'b0;
    $display("read  addr=%h data=%h", a, d);
  endtask

  task automatic wait_com(input logic [3:0] v);
    int n;
    n = 0;
    while (fnd_com !== v && n < 200) begin @(posedge clk); #1; n++; end
    if (fnd_com !== v) timeout_fail("wait_com");
  endtask

  // Syncs to the start of digit 0 and checks a full frame at 4 clocks per digit.
  task automatic check_display(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                               input logic [7:0] s2, input logic [7:0] s3);
    logic [7:0] segs [4];
    logic [3:0] one, exp_com;
    segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
    wait_com(4'b0111);
    wait_com(4'b1110);
    for (int i = 0; i < 16; i++) begin
      one = 4'b0001 << (i / 4);
      exp_com = ~one;
      chk({tag, "_com"}, {28'd0, fnd_com}, {28'd0, exp_com});
      chk({tag, "_seg"}, {24'd0, fnd_seg}, {24'd0, segs[i / 4]});
      @(posedge clk); #1;
    end
    $display("display %s checked: %h %h %h %h", tag, s3, s2, s1, s0);
  endtask

  task automatic run_len(input bit want_off, output int len);
    len = 0;
    while (((fnd_com === 4'b1111) == want_off) && len < 100) begin @(posedge clk); #1; len++; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int n, on_len, off_len;

    repeat (3) @(posedge clk); #1;
    chk("rst_com", {28'd0, fnd_com}, 32'hF);
    chk("rst_seg", {24'd0, fnd_seg}, 32'hFF);
    chk("rst_hs", {28'd0, awready, bvalid, arready, rvalid}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    axi_read(4'h0, rd); chk("rst_ctrl", rd, 32'h0);
    axi_read(4'h4, rd); chk("rst_value", rd, 32'h0);
    axi_read(4'h8, rd); chk("rst_prescale", rd, 32'h0000C34F);
    axi_read(4'hC, rd); chk("rst_status", rd, 32'h0);
    chk("idle_com", {28'd0, fnd_com}, 32'hF);
    chk("idle_seg", {24'd0, fnd_seg}, 32'hFF);

    axi_write(4'h8, 32'd3, 4'hF);
    axi_write(4'h4, 32'h1234, 4'hF);
    axi_write(4'h0, 32'h1, 4'hF);
    check_display("hex1234", 8'h99, 8'hB0, 8'hA4, 8'hF9);

    axi_write(4'h0, 32'h3, 4'hF);
    repeat (25) @(posedge clk); #1;
    check_display("dec4660", 8'hC0, 8'h82, 8'h82, 8'h99);
    axi_write(4'h4, 32'h4D2, 4'hF);
    axi_read(4'hC, rd);
    chk("dec_busy_set", rd & 32'h1, 32'h1);
    n = 0;
    while (rd[0] === 1'b1 && n < 20) begin axi_read(4'hC, rd); n++; end
    chk("dec_busy_clear_ovf0", rd & 32'h3, 32'h0);
    axi_read(4'h4, rd); chk("dec_value_rb", rd, 32'h4D2);
    check_display("dec1234", 8'h99, 8'hB0, 8'hA4, 8'hF9);

    axi_write(4'h4, 32'h3039, 4'hF);
    repeat (25) @(posedge clk); #1;
    axi_read(4'hC, rd); chk("ovf_set", rd & 32'h3, 32'h2);
    check_display("dec2345", 8'h92, 8'h99, 8'hB0, 8'hA4);
    axi_write(4'h4, 32'h7, 4'hF);
    repeat (25) @(posedge clk); #1;
    axi_read(4'hC, rd); chk("ovf_clear", rd & 32'h3, 32'h0);
`ifdef FND_LEADING_ZERO_BLANK_EN
    check_display("dec7", 8'hF8, 8'hFF, 8'hFF, 8'hFF);
`else
    check_display("dec0007", 8'hF8, 8'hC0, 8'hC0, 8'hC0);
`endif

    axi_write(4'h8, 32'h0001_0001, 4'hF);
    axi_write(4'h0, 32'h5, 4'hF);
    wait_com(4'b1111);
    run_len(1'b1, off_len);
    run_len(1'b0, on_len);
    chk("blink_on_len", on_len, 32'd16);
    run_len(1'b1, off_len);
    chk("blink_off_len", off_len, 32'd16);
    run_len(1'b0, on_len);
    chk("blink_on_len2", on_len, 32'd16);
    axi_write(4'h0, 32'h1, 4'hF);
    repeat (2) @(posedge clk); #1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (fnd_com === 4'b1111) n++;
      @(posedge clk); #1;
    end
    chk("blink_off_all_on", n, 32'd0);

    axi_write(4'h8, 32'd3, 4'hF);
    axi_write(4'h4, 32'h1234, 4'hF);
    axi_write(4'h4, 32'hFF, 4'b0001);
    axi_read(4'h4, rd); chk("wstrb_byte0", rd, 32'h12FF);
    axi_write(4'h4, 32'hABCD_AB00, 4'b0010);
    axi_read(4'h4, rd); chk("wstrb_byte1", rd, 32'hABFF);
    axi_write(4'h0, 32'h0001_0001, 4'hF);
    check_display("hexdp", 8'h0E, 8'h8E, 8'h83, 8'h88);

    axi_write(4'h0, 32'h3, 4'hF);
    axi_write(4'h4, 32'h4D2, 4'hF);
    repeat (4) @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_com", {28'd0, fnd_com}, 32'hF);
    chk("midrst_seg", {24'd0, fnd_seg}, 32'hFF);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    axi_read(4'hC, rd); chk("midrst_status", rd, 32'h0);
    axi_read(4'h4, rd); chk("midrst_value", rd, 32'h0);
    axi_read(4'h8, rd); chk("midrst_prescale", rd, 32'h0000C34F);
    chk("midrst_com_idle", {28'd0, fnd_com}, 32'hF);
    axi_write(4'h8, 32'd3, 4'hF);
    axi_write(4'h4, 32'h4D2, 4'hF);
    axi_write(4'h0, 32'h3, 4'hF);
    repeat (25) @(posedge clk); #1;
    axi_read(4'hC, rd); chk("post_rst_conv_idle", rd & 32'h3, 32'h0);
    check_display("post_rst_1234", 8'h99, 8'hB0, 8'hA4, 8'hF9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
